// File: rtl/alu_seq.sv
// Sequential ALU: registered single-cycle ops, bit-serial variable shift and an
// optional shift-add multiplier on opcode 011 (built when ALU_MUL_EN is defined).
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             overflow
);

    localparam logic [2:0] OpOr    = 3'b000;
    localparam logic [2:0] OpAnd   = 3'b001;
    localparam logic [2:0] OpAdd   = 3'b010;
    localparam logic [2:0] OpMul   = 3'b011;
    localparam logic [2:0] OpNeg   = 3'b100;
    localparam logic [2:0] OpNot   = 3'b101;
    localparam logic [2:0] OpComp  = 3'b110;
    localparam logic [2:0] OpShift = 3'b111;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {StIdle, StShift, StMul, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;

    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] b_mag;
    logic [SHW-1:0]   shift_cnt;

    assign add_sum   = a + b;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    // Shifts of WIDTH or more all clear the word, so the count saturates there.
    assign shift_cnt = (b_mag >= WIDTH'(WIDTH)) ? SHW'(WIDTH) : SHW'(b_mag);

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH:0]   mul_sum;

    // r_q holds the multiplier and collects the low product bits as it shifts out.
    assign mul_sum = {1'b0, hi_q} + (r_q[0] ? {1'b0, opa_q} : '0);
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
`ifdef ALU_MUL_EN
        opa_d   = opa_q;
        hi_d    = hi_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StDone;
                    ovf_d   = 1'b0;
                    unique case (alu_op)
                        OpOr:  r_d = a | b;
                        OpAnd: r_d = a & b;
                        OpAdd: begin
                            r_d   = add_sum;
                            ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        OpMul: begin
`ifdef ALU_MUL_EN
                            r_d     = b;
                            opa_d   = a;
                            hi_d    = '0;
                            cnt_d   = SHW'(WIDTH);
                            state_d = StMul;
`else
                            r_d   = '0;
                            ovf_d = 1'b1;
`endif
                        end
                        OpNeg: begin
                            r_d   = -b;
                            ovf_d = (b == {1'b1, {(WIDTH-1){1'b0}}});
                        end
                        OpNot: r_d = ~a;
                        OpComp: begin
                            if ($signed(a) < $signed(b)) begin
                                r_d = '1;
                            end else if (a == b) begin
                                r_d = '0;
                            end else begin
                                r_d = WIDTH'(1);
                            end
                        end
                        OpShift: begin
                            r_d    = a;
                            left_d = ~b[WIDTH-1];
                            cnt_d  = shift_cnt;
                            if (shift_cnt != '0) begin
                                state_d = StShift;
                            end
                        end
                        default: r_d = '0;
                    endcase
                end
            end
            StShift: begin
                if (left_q) begin
                    ovf_d = ovf_q | r_q[WIDTH-1];
                    r_d   = r_q << 1;
                end else begin
                    ovf_d = ovf_q | r_q[0];
                    r_d   = r_q >> 1;
                end
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = StDone;
                end
            end
`ifdef ALU_MUL_EN
            StMul: begin
                hi_d  = mul_sum[WIDTH:1];
                r_d   = {mul_sum[0], r_q[WIDTH-1:1]};
                ovf_d = |mul_sum[WIDTH:1];
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
`ifdef ALU_MUL_EN
            opa_q   <= '0;
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
`ifdef ALU_MUL_EN
            opa_q   <= opa_d;
            hi_q    <= hi_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign r         = r_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed vectors, randomized ops
// against an arithmetic reference model, backpressure, back-to-back and mid-op reset.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         overflow;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: results from plain signed/unsigned integer arithmetic.
    function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] x,
                                      input logic [W-1:0] y, output logic [W-1:0] er,
                                      output logic eo, output int el);
        longint          sx, sy, s, smax, smin;
        longint unsigned ux, uy, p, mask;
        int              n;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        er = '0;
        eo = 1'b0;
        el = 1;
        case (op)
            3'd0: er = x | y;
            3'd1: er = x & y;
            3'd2: begin
                s  = sx + sy;
                er = s[W-1:0];
                eo = (s > smax) || (s < smin);
            end
            3'd3: begin
`ifdef ALU_MUL_EN
                p  = ux * uy;
                er = p[W-1:0];
                eo = (p >> W) != 0;
                el = 1 + W;
`else
                er = '0;
                eo = 1'b1;
`endif
            end
            3'd4: begin
                s  = -sy;
                er = s[W-1:0];
                eo = s > smax;
            end
            3'd5: er = ~x;
            3'd6: begin
                if (sx < sy) er = '1;
                else if (sx == sy) er = '0;
                else er = W'(1);
            end
            default: begin
                n = (sy < 0) ? int'(-sy) : int'(sy);
                if (n > W) n = W;
                if (sy >= 0) begin
                    p  = ux << n;
                    er = p[W-1:0];
                    eo = (p >> W) != 0;
                end else begin
                    mask = (longint'(1) << n) - 1;
                    p    = ux >> n;
                    er   = p[W-1:0];
                    eo   = (ux & mask) != 0;
                end
                el = 1 + n;
            end
        endcase
    endfunction

    // Issue one request with out_ready high; report what came back and how late.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] gr, output logic go, output int glat,
                          output logic gv);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        alu_op    = op;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        alu_op   = 3'($urandom);
        glat     = 1;
        while (!out_valid && glat < 40) begin
            @(posedge clk); #1;
            glat++;
        end
        gv = out_valid;
        gr = r;
        go = overflow;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        alu_op    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_checks++;
        if (r !== '0 || overflow !== 1'b0)
            $display("FAIL reset_result: r=%h ovf=%b, want r=0 ovf=0", r, overflow);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        else n_pass++;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] er;
        logic         eo;
        int           el;
    } vec_t;

    task automatic test_directed();
        vec_t         v[13];
        logic [W-1:0] gr;
        logic         go, gv;
        int           gl;
        v[0]  = '{3'd2, 16'd40000, 16'd40000, 16'd14464, 1'b1, 1};
        v[1]  = '{3'd2, 16'd50,    16'd100,   16'd150,   1'b0, 1};
        v[2]  = '{3'd1, 16'h001F,  16'hFFEA,  16'h000A,  1'b0, 1};
        v[3]  = '{3'd4, 16'h0000,  16'h8000,  16'h8000,  1'b1, 1};
        v[4]  = '{3'd6, 16'd100,   16'd200,   16'hFFFF,  1'b0, 1};
        v[5]  = '{3'd6, 16'd100,   16'd100,   16'h0000,  1'b0, 1};
        v[6]  = '{3'd6, 16'd100,   16'd50,    16'h0001,  1'b0, 1};
        v[7]  = '{3'd7, 16'd128,   16'd1,     16'd256,   1'b0, 2};
        v[8]  = '{3'd7, 16'd10000, 16'hFFFF,  16'd5000,  1'b0, 2};
        v[9]  = '{3'd7, 16'h8000,  16'd1,     16'h0000,  1'b1, 2};
        v[10] = '{3'd7, 16'h1234,  16'd0,     16'h1234,  1'b0, 1};
        v[11] = '{3'd7, 16'h1234,  16'd100,   16'h0000,  1'b1, 17};
`ifdef ALU_MUL_EN
        v[12] = '{3'd3, 16'd300,   16'd200,   16'd60000, 1'b0, 17};
`else
        v[12] = '{3'd3, 16'd300,   16'd200,   16'd0,     1'b1, 1};
`endif
        for (int i = 0; i < 13; i++) begin
            run_op(v[i].op, v[i].x, v[i].y, gr, go, gl, gv);
            n_checks++;
            if (gv !== 1'b1 || gr !== v[i].er || go !== v[i].eo)
                $display("FAIL directed[%0d]: valid=%b r=%h ovf=%b, want valid=1 r=%h ovf=%b",
                         i, gv, gr, go, v[i].er, v[i].eo);
            else n_pass++;
            n_checks++;
            if (gl !== v[i].el)
                $display("FAIL directed_lat[%0d]: latency=%0d, want %0d", i, gl, v[i].el);
            else n_pass++;
        end
`ifdef ALU_MUL_EN
        run_op(3'd3, 16'd300, 16'd300, gr, go, gl, gv);
        n_checks++;
        if (gr !== 16'd24464 || go !== 1'b1)
            $display("FAIL mul_ovf: r=%0d ovf=%b, want r=24464 ovf=1", gr, go);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, gr, er;
        logic [2:0]   op;
        logic         go, gv, eo;
        int           gl, el;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            x  = W'($urandom);
            y  = W'($urandom);
            if (op == 3'd7 && $urandom_range(0, 1) == 1) begin
                y = W'($urandom_range(0, 20));
                if ($urandom_range(0, 1) == 1) y = -y;
            end
            ref_model(op, x, y, er, eo, el);
            run_op(op, x, y, gr, go, gl, gv);
            n_checks++;
            if (gv !== 1'b1 || gr !== er || go !== eo || gl !== el)
                $display("FAIL random[%0d] op=%0d a=%h b=%h: valid=%b r=%h ovf=%b lat=%0d, want 1 %h %b %0d",
                         i, op, x, y, gv, gr, go, gl, er, eo, el);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] er;
        logic         eo;
        int           el;
        int           guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        ref_model(3'd2, 16'h7000, 16'h1234, er, eo, el);
        alu_op    = 3'd2;
        a         = 16'h7000;
        b         = 16'h1234;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        // Keep requesting with different operands: they must be ignored while busy.
        alu_op = 3'd0;
        a      = 16'hFFFF;
        b      = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || r !== er || overflow !== eo)
                $display("FAIL backpressure[%0d]: valid=%b ready=%b r=%h ovf=%b, want 1 0 %h %b",
                         i, out_valid, in_ready, r, overflow, er, eo);
            else n_pass++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL backpressure_release: ready=%b valid=%b, want 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] px, py, er;
        logic [2:0]   pop;
        logic         pre_ready, eo;
        int           el;
        logic [2:0]   ops[6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
        out_ready = 1'b1;
        alu_op    = ops[$urandom_range(0, 5)];
        a         = W'($urandom);
        b         = W'($urandom);
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pre_ready = in_ready;
            pop = alu_op;
            px  = a;
            py  = b;
            @(posedge clk); #1;
            if (pre_ready) begin
                ref_model(pop, px, py, er, eo, el);
                n_checks++;
                if (out_valid !== 1'b1 || r !== er || overflow !== eo)
                    $display("FAIL b2b[%0d] op=%0d: valid=%b r=%h ovf=%b, want 1 %h %b",
                             i, pop, out_valid, r, overflow, er, eo);
                else n_pass++;
                alu_op = ops[$urandom_range(0, 5)];
                a      = W'($urandom);
                b      = W'($urandom);
            end else begin
                n_checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1)
                    $display("FAIL b2b_gap[%0d]: valid=%b ready=%b, want 0 1", i, out_valid, in_ready);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic seen_valid = 1'b0;
        int   guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        alu_op    = 3'd7;
        a         = 16'h00F3;
        b         = 16'd12;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            if (out_valid) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || r !== '0 || overflow !== 1'b0)
            $display("FAIL reset_mid_state: ready=%b valid=%b r=%h ovf=%b, want 1 0 0 0",
                     in_ready, out_valid, r, overflow);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0)
            $display("FAIL reset_mid_discard: out_valid=%b seen, want 0", seen_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
